zsdram_rw_arbiter: RTL and testbench
====================================

// Module: zsdram_rw_arbiter
// PURPOSE
// - Shares the single ZSDRAM_Module_Base command port between a read requester (TFT43 display adapter)
//   and a write requester (photon-count FIFO drain path). Replaces the ad-hoc address mux in the top level.
// - Latches address and data per grant and drives iCall/iAddr/iData. Returns oData and per-port done pulses.
// - Read-priority arbitration with a write-starvation bound. Optional watchdog on the SDRAM done handshake.
// PARAMETERS
// - RD_MAX_CONSEC, default 4: maximum consecutive read grants while wr_req is pending.
// - TIMEOUT_CYC, default 1024: cycles in a call state before abort. Used only with ARB_TIMEOUT_EN.
// PORTS
// - clk_133MHz_210  in   1   system clock, 133 MHz, 210 deg phase
// - rst_n           in   1   reset, asynchronous, active-low
// - rd_req          in   1   read request; held high with rd_addr stable until rd_done
// - rd_addr         in   24  {bank[1:0],row[12:0],col[8:0]}
// - rd_data         out  16  read result; valid while rd_done=1 and held until the next read completes
// - rd_done         out  1   1-cycle pulse, read complete
// - wr_req          in   1   write request; held high with wr_addr/wr_data stable until wr_done
// - wr_addr         in   24  write address, same format as rd_addr
// - wr_data         in   16  write data
// - wr_done         out  1   1-cycle pulse, write complete
// - sdram_addr      out  24  to iAddr
// - sdram_wdata     out  16  to iData
// - sdram_call      out  2   to iCall; [1]=write, [0]=read; at most one bit set
// - sdram_done      in   2   from oDone; [1]=write done, [0]=read done
// - sdram_rdata     in   16  from oData
// - busy            out  1   high in every state except IDLE
// - err_timeout     out  1   1-cycle pulse on watchdog abort; tied 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
// - Reset values: all outputs 0. State = IDLE. Latches, starvation counter and timer = 0.
// - FSM states: IDLE, RD_CALL, WR_CALL, RD_ACK, WR_ACK.
// - Grant is decided in IDLE:
//   - rd_req && (!wr_req || starve_cnt < RD_MAX_CONSEC) -> RD_CALL
//   - otherwise, if wr_req -> WR_CALL
//   - otherwise stay in IDLE.
// - On grant edge, the address (and, for writes, the data) is latched into sdram_addr/sdram_wdata.
//   The matching sdram_call bit is set on the same edge, so call is visible one cycle after the request is sampled.
// - RD_CALL: on the edge where sdram_done[0]=1:
//   - clear sdram_call[0]
//   - rd_data <= sdram_rdata
//   - move to RD_ACK.
//   sdram_done[1] is ignored in this state.
// - WR_CALL: on sdram_done[1]=1, clear sdram_call[1] and move to WR_ACK. sdram_done[0] is ignored.
// - RD_ACK / WR_ACK: the matching done output is high for exactly this cycle. New requests are ignored here.
//   The requester drops req on the same edge it samples done. Next state is always IDLE.
//   Minimum issue spacing is therefore 1 grant per (SDRAM latency + 3) cycles.
// - Starvation counter:
//   - +1 on each read grant while wr_req=1, saturating at RD_MAX_CONSEC
//   - cleared on a write grant, or in IDLE when wr_req=0
//   - RD_MAX_CONSEC=0 gives write priority.
// - Simultaneous rd_req and wr_req with the counter below the limit: read wins; the write waits in IDLE.
// - A requester deasserting req before its done: undefined. The transaction still completes, and done is
//   still pulsed to that port.
// - rst_n asserted mid-transaction: sdram_call drops asynchronously and no done is issued.
//   ZSDRAM_Module_Base shares rst_n and restarts in step.
// - The sdram_addr/sdram_wdata latches hold their values in IDLE; no glitching between transactions.
// CONFIGURATION
// - ARB_TIMEOUT_EN defined:
//   - a 16-bit timer clears on entry to RD_CALL/WR_CALL and counts each cycle
//   - at TIMEOUT_CYC-1 with no done: clear the call bit, pulse err_timeout, go to RD_ACK/WR_ACK
//   - on a read abort, rd_data <= 16'hFFFF
//   - the requester still receives its done, so no requester deadlocks.
// - ARB_TIMEOUT_EN undefined: no timer logic; a call state waits indefinitely; err_timeout = 1'b0.
// STRUCTURE
// - Shared package/include zsdram_arb_pkg holds:
//   - state encoding localparams (ST_IDLE..ST_WR_ACK, 3-bit)
//   - CALL_WR=1, CALL_RD=0 bit indices
//   - SDRAM_AW=24, SDRAM_DW=16
//   The top level and ZTFT43_Adapter reuse these.
// - Single module. The grant decision stays inline as one combinational next-state block.
// - No sub-module: the timer is too small to justify one.
// TESTING
// - Reset: hold rst_n=0 with rd_req=wr_req=1 -> all outputs 0.
//   Release -> RD_CALL with sdram_call=2'b01 one cycle later.
// - Single read: rd_addr=24'h00_0123; model returns sdram_rdata=16'hA5A5 with done[0] after 6 cycles
//   -> sdram_addr=24'h000123; rd_done pulses 1 cycle after done[0]; rd_data=16'hA5A5.
// - Single write: wr_addr=24'h12_3456, wr_data=16'h5A5A
//   -> sdram_call=2'b10, sdram_wdata=16'h5A5A, one wr_done pulse, no rd_done.
// - Simultaneous requests -> read granted first, write granted in the next IDLE.
//   sdram_call never shows 2'b11.
// - Starvation: rd_req held continuously (re-asserted after each done) with wr_req=1
//   -> exactly 4 read grants, then 1 write, then reads resume.
// - ARB_TIMEOUT_EN, TIMEOUT_CYC=16, model never returns done
//   -> call drops after 16 cycles, err_timeout and rd_done pulse together, rd_data=16'hFFFF.
//   Without the macro: busy stays high for more than 2000 cycles.

Source files
------------

// File: rtl/zsdram_arb_pkg.sv
// Shared definitions for the ZSDRAM command-port arbiter and its neighbours
// (top level, ZTFT43_Adapter): state encoding, call-bit indices, bus widths.
package zsdram_arb_pkg;

  localparam int SDRAM_AW = 24;
  localparam int SDRAM_DW = 16;

  // Bit positions inside iCall / oDone
  localparam int CALL_RD = 0;
  localparam int CALL_WR = 1;

  // Arbiter FSM encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_CALL = 3'd1;
  localparam logic [2:0] ST_WR_CALL = 3'd2;
  localparam logic [2:0] ST_RD_ACK  = 3'd3;
  localparam logic [2:0] ST_WR_ACK  = 3'd4;

  // True while a command is outstanding at the SDRAM controller
  function automatic logic st_is_call(input logic [2:0] s);
    return (s == ST_RD_CALL) || (s == ST_WR_CALL);
  endfunction

endpackage

// File: rtl/zsdram_rw_arbiter.sv
// Read/write arbiter in front of the single ZSDRAM_Module_Base command port.
// Reads (display refresh) win by default; a saturating starvation counter
// forces a write grant after RD_MAX_CONSEC back-to-back reads while a write
// is pending. Address/data are latched at grant and held between commands.
// Optional watchdog on the done handshake: define ARB_TIMEOUT_EN.
module zsdram_rw_arbiter
  import zsdram_arb_pkg::*;
#(
  parameter int RD_MAX_CONSEC = 4,
  parameter int TIMEOUT_CYC   = 1024
) (
  input  logic                clk_133MHz_210,
  input  logic                rst_n,
  input  logic                rd_req,
  input  logic [SDRAM_AW-1:0] rd_addr,
  output logic [SDRAM_DW-1:0] rd_data,
  output logic                rd_done,
  input  logic                wr_req,
  input  logic [SDRAM_AW-1:0] wr_addr,
  input  logic [SDRAM_DW-1:0] wr_data,
  output logic                wr_done,
  output logic [SDRAM_AW-1:0] sdram_addr,
  output logic [SDRAM_DW-1:0] sdram_wdata,
  output logic [1:0]          sdram_call,
  input  logic [1:0]          sdram_done,
  input  logic [SDRAM_DW-1:0] sdram_rdata,
  output logic                busy,
  output logic                err_timeout
);

  // Counter just wide enough to hold RD_MAX_CONSEC (0 still needs one bit)
  localparam int              SCW    = (RD_MAX_CONSEC < 1) ? 1 : $clog2(RD_MAX_CONSEC + 1);
  localparam logic [SCW-1:0]  SC_MAX = SCW'(RD_MAX_CONSEC);

  logic [2:0]          r_state;
  logic [2:0]          w_nxt;
  logic [1:0]          r_call;
  logic [SDRAM_AW-1:0] r_addr;
  logic [SDRAM_DW-1:0] r_wdata;
  logic [SDRAM_DW-1:0] r_rdata;
  logic [SCW-1:0]      r_starve;

  logic w_grant_rd;
  logic w_grant_wr;
  logic w_rd_end;
  logic w_wr_end;
  logic w_abort;
  logic w_tmo;

  // Grant decision and call/ack sequencing
  always_comb begin
    w_nxt      = r_state;
    w_grant_rd = 1'b0;
    w_grant_wr = 1'b0;
    w_rd_end   = 1'b0;
    w_wr_end   = 1'b0;
    w_abort    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rd_req && (!wr_req || (r_starve < SC_MAX))) begin
          w_grant_rd = 1'b1;
          w_nxt      = ST_RD_CALL;
        end else if (wr_req) begin
          w_grant_wr = 1'b1;
          w_nxt      = ST_WR_CALL;
        end
      end
      ST_RD_CALL: begin
        // Write-done is not ours here and is ignored
        if (sdram_done[CALL_RD]) begin
          w_rd_end = 1'b1;
          w_nxt    = ST_RD_ACK;
        end else if (w_tmo) begin
          w_rd_end = 1'b1;
          w_abort  = 1'b1;
          w_nxt    = ST_RD_ACK;
        end
      end
      ST_WR_CALL: begin
        if (sdram_done[CALL_WR]) begin
          w_wr_end = 1'b1;
          w_nxt    = ST_WR_ACK;
        end else if (w_tmo) begin
          w_wr_end = 1'b1;
          w_abort  = 1'b1;
          w_nxt    = ST_WR_ACK;
        end
      end
      // Requests are ignored in the ack cycle; requester drops req here
      ST_RD_ACK: w_nxt = ST_IDLE;
      ST_WR_ACK: w_nxt = ST_IDLE;
      default:   w_nxt = ST_IDLE;
    endcase
  end

  // State, command latches and read-data capture
  always_ff @(posedge clk_133MHz_210 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_call  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_grant_rd) begin
        r_call <= 2'b01;
        r_addr <= rd_addr;
      end else if (w_grant_wr) begin
        r_call  <= 2'b10;
        r_addr  <= wr_addr;
        r_wdata <= wr_data;
      end else if (w_rd_end || w_wr_end) begin
        r_call <= 2'b00;
      end
      // An aborted read returns all-ones so the display shows a marker
      if (w_rd_end)
        r_rdata <= w_abort ? {SDRAM_DW{1'b1}} : sdram_rdata;
    end
  end

  // Starvation counter: consecutive reads granted over a pending write
  always_ff @(posedge clk_133MHz_210 or negedge rst_n) begin
    if (!rst_n)
      r_starve <= '0;
    else if (w_grant_wr)
      r_starve <= '0;
    else if (w_grant_rd && wr_req) begin
      if (r_starve < SC_MAX)
        r_starve <= r_starve + 1'b1;
    end else if ((r_state == ST_IDLE) && !wr_req)
      r_starve <= '0;
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] r_timer;
  logic        r_err;

  assign w_tmo = st_is_call(r_state) && (r_timer == TO_LAST);

  // Cycles spent in the current call state; restarts on every grant
  always_ff @(posedge clk_133MHz_210 or negedge rst_n) begin
    if (!rst_n)
      r_timer <= '0;
    else if (w_grant_rd || w_grant_wr)
      r_timer <= '0;
    else if (st_is_call(r_state))
      r_timer <= r_timer + 16'd1;
  end

  // Abort flag lines up with the requester's done pulse
  always_ff @(posedge clk_133MHz_210 or negedge rst_n) begin
    if (!rst_n)
      r_err <= 1'b0;
    else
      r_err <= w_abort;
  end

  assign err_timeout = r_err;
`else
  assign w_tmo       = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign sdram_call  = r_call;
  assign sdram_addr  = r_addr;
  assign sdram_wdata = r_wdata;
  assign rd_data     = r_rdata;
  assign rd_done     = (r_state == ST_RD_ACK);
  assign wr_done     = (r_state == ST_WR_ACK);
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_zsdram_rw_arbiter.sv
// Self-checking bench for zsdram_rw_arbiter: SDRAM controller model with
// fixed latency, scoreboard of expected completions in grant order.
// Timeout branch follows ARB_TIMEOUT_EN.
module tb_zsdram_rw_arbiter;

  localparam int LAT = 6;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_req, wr_req;
  logic [23:0] rd_addr, wr_addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        rd_done, wr_done;
  logic [23:0] sdram_addr;
  logic [15:0] sdram_wdata;
  logic [1:0]  sdram_call;
  logic [1:0]  sdram_done;
  logic [15:0] sdram_rdata;
  logic        busy, err_timeout;

  always #4 clk = ~clk;

  zsdram_rw_arbiter #(.RD_MAX_CONSEC(4), .TIMEOUT_CYC(TMO)) dut (
    .clk_133MHz_210(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_done(rd_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .sdram_addr(sdram_addr), .sdram_wdata(sdram_wdata), .sdram_call(sdram_call),
    .sdram_done(sdram_done), .sdram_rdata(sdram_rdata),
    .busy(busy), .err_timeout(err_timeout)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory model read data: a fixed scramble of the address
  function automatic logic [15:0] mdat(input logic [23:0] a);
    return a[15:0] ^ 16'hA486;
  endfunction

  typedef struct packed {
    logic        wr;
    logic [23:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];

  function automatic void push_rd(input logic [23:0] a, input logic [15:0] d);
    sb.push_back({1'b0, a, d});
  endfunction
  function automatic void push_wr(input logic [23:0] a, input logic [15:0] d);
    sb.push_back({1'b1, a, d});
  endfunction

  // SDRAM controller model: done on the LAT-th cycle a call is visible
  bit model_en = 1'b1;
  bit seen11   = 1'b0;
  int m_cnt    = 0;
  always @(negedge clk) begin
    if (sdram_call == 2'b11) seen11 = 1'b1;
    if (sdram_call == 2'b00) begin
      m_cnt      = 0;
      sdram_done = 2'b00;
    end else begin
      m_cnt++;
      if (model_en && m_cnt == LAT) begin
        sdram_done  = sdram_call;
        sdram_rdata = mdat(sdram_addr);
      end else
        sdram_done = 2'b00;
    end
  end

  // Scoreboard: each done pulse retires the oldest expected transaction
  always @(negedge clk) begin : sb_mon
    exp_t e;
    if (rst_n && (rd_done || wr_done)) begin
      if (sb.size() == 0)
        chk("sb_unexpected_done", {62'd0, rd_done, wr_done}, 64'd0);
      else begin
        e = sb.pop_front();
        chk("sb_kind", {62'd0, rd_done, wr_done}, e.wr ? 64'd1 : 64'd2);
        chk("sb_addr", 64'(sdram_addr), 64'(e.addr));
        if (e.wr) chk("sb_wdata", 64'(sdram_wdata), 64'(e.data));
        else      chk("sb_rdata", 64'(rd_data), 64'(e.data));
      end
    end
  end

  // Drive n_rd back-to-back reads (re-asserted after each done) and optionally one write
  task automatic run(input int n_rd, input logic [23:0] rbase, input bit do_wr,
                     input logic [23:0] wa, input logic [15:0] wd);
    int rl = n_rd;
    int k  = 0;
    bit wp = do_wr;
    int t  = 0;
    rd_addr = rbase; rd_req = (rl > 0);
    wr_addr = wa; wr_data = wd; wr_req = wp;
    while ((rl > 0 || wp) && t < 600) begin
      @(negedge clk); t++;
      if (rd_done) begin
        rl--; k++;
        if (rl > 0) rd_addr = rbase + 24'(k);
        else rd_req = 1'b0;
      end
      if (wr_done) begin
        wp = 1'b0; wr_req = 1'b0;
      end
    end
    chk("run_complete", {62'd0, rl != 0, wp}, 64'd0);
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cc, t, nr;
    bit first;
    rd_req = 1'b1; wr_req = 1'b1;
    rd_addr = 24'h0A0B0C; wr_addr = 24'h0D0E0F; wr_data = 16'h1234;
    sdram_done = 2'b00; sdram_rdata = 16'h0000;

    // Reset with both requests held
    repeat (3) @(negedge clk);
    chk("rst_outs", {2'd0, sdram_call, sdram_addr, sdram_wdata, rd_data,
                     rd_done, wr_done, busy, err_timeout}, 64'd0);
    push_rd(24'h0A0B0C, mdat(24'h0A0B0C));
    push_wr(24'h0D0E0F, 16'h1234);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_call", 64'(sdram_call), 64'd1);
    chk("rst_rel_busy", 64'(busy), 64'd1);
    run(1, 24'h0A0B0C, 1'b1, 24'h0D0E0F, 16'h1234);
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // Single read
    push_rd(24'h000123, 16'hA5A5);
    rd_addr = 24'h000123; rd_req = 1'b1;
    cc = 0; t = 0;
    while (!rd_done && t < 100) begin
      @(negedge clk); t++;
      if (sdram_call[0]) begin
        cc++;
        if (cc == 1) chk("rd_addr_latch", 64'(sdram_addr), 64'h000123);
      end
    end
    chk("rd_done_seen", 64'(rd_done), 64'd1);
    chk("rd_call_cycles", 64'(cc), 64'(LAT));
    chk("rd_ack_call", 64'(sdram_call), 64'd0);
    chk("rd_data", 64'(rd_data), 64'hA5A5);
    rd_req = 1'b0;
    @(negedge clk);
    chk("rd_done_1cyc", 64'(rd_done), 64'd0);
    chk("rd_data_hold", 64'(rd_data), 64'hA5A5);

    // Single write
    push_wr(24'h123456, 16'h5A5A);
    wr_addr = 24'h123456; wr_data = 16'h5A5A; wr_req = 1'b1;
    t = 0; nr = 0; first = 1'b1;
    while (!wr_done && t < 100) begin
      @(negedge clk); t++;
      if (rd_done) nr++;
      if (sdram_call != 2'b00 && first) begin
        first = 1'b0;
        chk("wr_call", 64'(sdram_call), 64'd2);
        chk("wr_wdata", 64'(sdram_wdata), 64'h5A5A);
      end
    end
    chk("wr_done_seen", 64'(wr_done), 64'd1);
    chk("wr_no_rd_done", 64'(nr), 64'd0);
    wr_req = 1'b0;
    @(negedge clk);
    chk("wr_done_1cyc", 64'(wr_done), 64'd0);
    repeat (3) @(negedge clk);
    chk("latch_hold_idle", {24'd0, sdram_addr, sdram_wdata}, {24'd0, 24'h123456, 16'h5A5A});

    // Simultaneous requests: read first, write next
    push_rd(24'h200010, mdat(24'h200010));
    push_wr(24'h300020, 16'hBEEF);
    run(1, 24'h200010, 1'b1, 24'h300020, 16'hBEEF);

    // Starvation bound: 4 reads, 1 write, reads resume
    for (int i = 0; i < 4; i++) push_rd(24'h010000 + 24'(i), mdat(24'h010000 + 24'(i)));
    push_wr(24'h3F0000, 16'hC0DE);
    for (int i = 4; i < 6; i++) push_rd(24'h010000 + 24'(i), mdat(24'h010000 + 24'(i)));
    run(6, 24'h010000, 1'b1, 24'h3F0000, 16'hC0DE);
    repeat (2) @(negedge clk);

    // Reset mid-transaction: call drops at once, no done
    rd_addr = 24'h0000AA; rd_req = 1'b1;
    t = 0;
    while (sdram_call == 2'b00 && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_call_drop", 64'(sdram_call), 64'd0);
    chk("async_busy_drop", 64'(busy), 64'd0);
    rd_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 3) @(negedge clk);

    // No done from the SDRAM side
    model_en = 1'b0;
    rd_addr = 24'h0000BB; rd_req = 1'b1;
`ifdef ARB_TIMEOUT_EN
    push_rd(24'h0000BB, 16'hFFFF);
    cc = 0; t = 0;
    while (!rd_done && t < 200) begin
      @(negedge clk); t++;
      if (sdram_call[0]) cc++;
    end
    chk("tmo_call_cycles", 64'(cc), 64'(TMO));
    chk("tmo_err_with_done", {62'd0, err_timeout, rd_done}, 64'd3);
    chk("tmo_rd_data", 64'(rd_data), 64'hFFFF);
    rd_req = 1'b0;
    @(negedge clk);
    chk("tmo_err_1cyc", 64'(err_timeout), 64'd0);
`else
    repeat (2100) @(negedge clk);
    chk("no_tmo_busy", 64'(busy), 64'd1);
    chk("no_tmo_call", 64'(sdram_call), 64'd1);
    chk("no_tmo_err", 64'(err_timeout), 64'd0);
    rd_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
    model_en = 1'b1;
    repeat (2) @(negedge clk);

    chk("call_never_11", 64'(seen11), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
